// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of fifo_rd_stream.
// The master modport is the adapter. The slave modport is the FIFO plus the consumer.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO with one-cycle read latency into a valid/ready stream.
// A 2-entry skid buffer sustains one word per clock. The block also counts delivered words.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    fifo_rd_stream_if.master     bus,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_word_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_next;
    logic                  r_inflight;
    logic                  r_head;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  w_pop;
    logic                  w_rd_en;
    logic [2:0]            w_level;
    logic                  w_tail;

    assign w_pop   = (r_occ != 2'd0) && bus.m_ready;
    // Buffer level one edge ahead: with it, a read is issued only if its data will fit.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    // The level is at most 1 whenever data is captured, so head + occ (mod 2) is the free slot.
    assign w_tail  = r_head ^ r_occ[0];

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_enable) w_state_next = StRun;
            end
            StRun: begin
                w_rd_en = !bus.fifo_empty && (w_level <= 3'd1);
                if (!i_enable) w_state_next = StStop;
            end
            StStop: begin
                if (i_enable) begin
                    w_state_next = StRun;
                end else if ((r_occ == 2'd0) && !r_inflight) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_occ_next = r_occ;
        unique case ({r_inflight, w_pop})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_word_cnt <= '0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_head     <= ~r_head;
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
            if (r_inflight) begin
                r_buf[w_tail] <= bus.fifo_rd_data;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = (r_occ != 2'd0);
    assign bus.m_data     = r_buf[r_head];
    assign o_busy         = (r_state != StIdle);
    assign o_word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream. A behavioural FIFO drives the DUT.
// A second instance with a 4-bit counter shares the same stimulus so that counter wrap can be observed.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic        busy4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(8)) bus ();
    fifo_rd_stream_if #(.DATA_WIDTH(8)) bus4 ();

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .bus        (bus),
        .o_busy     (busy),
        .o_word_cnt (word_cnt)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .bus        (bus4),
        .o_busy     (busy4),
        .o_word_cnt (word_cnt4)
    );

    // Behavioural FIFO: registered read data, flushed by reset
    logic [7:0] mem [256];
    logic [7:0] wp   = 8'd0;
    logic [7:0] rp   = 8'd0;
    logic [7:0] rd_q = 8'd0;

    assign bus.fifo_empty    = (wp == rp);
    assign bus.fifo_rd_data  = rd_q;
    assign bus4.fifo_empty   = bus.fifo_empty;
    assign bus4.fifo_rd_data = rd_q;
    assign bus4.m_ready      = bus.m_ready;

    always @(posedge clk) begin
        if (rst) begin
            rp <= wp;
        end else if (bus.fifo_rd_en && (wp != rp)) begin
            rd_q <= mem[rp];
            rp   <= rp + 8'd1;
        end
    end

    // Monitor: samples mid-cycle, records reads, handshakes and buffered-level violations
    int         cyc      = 0;
    int         n_rd     = 0;
    int         n_got    = 0;
    int         n_bad_rd = 0;
    int         n_ovf    = 0;
    int         outst    = 0;
    logic [7:0] got     [512];
    int         got_cyc [512];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fifo_rd_en) n_rd <= n_rd + 1;
        if (bus.fifo_rd_en && bus.fifo_empty) n_bad_rd <= n_bad_rd + 1;
        if (bus.m_valid && bus.m_ready && (n_got < 512)) begin
            got[n_got]     <= bus.m_data;
            got_cyc[n_got] <= cyc;
            n_got          <= n_got + 1;
        end
        if (rst) begin
            outst <= 0;
        end else begin
            outst <= outst + int'(bus.fifo_rd_en) - int'(bus.m_valid && bus.m_ready);
            if (outst + int'(bus.fifo_rd_en) - int'(bus.m_valid && bus.m_ready) > 2)
                n_ovf <= n_ovf + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int b_rd;
    int b_got;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wp] = v;
        wp      = wp + 8'd1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        b_rd  = n_rd;
        b_got = n_got;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); else n_pass++;
        n_chk++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_chk++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data: got %h want 00", bus.m_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (word_cnt !== 16'd0) $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic_drain();
        int lat;
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.m_valid) begin
                lat = k;
                break;
            end
        end
        n_chk++; if (lat !== 3) $display("FAIL basic_latency: got %0d want 3", lat); else n_pass++;
        for (int k = 0; k < 8; k++) tick();
        n_chk++; if (n_rd - b_rd !== 3) $display("FAIL basic_reads: got %0d want 3", n_rd - b_rd); else n_pass++;
        n_chk++; if (n_got - b_got !== 3) $display("FAIL basic_words: got %0d want 3", n_got - b_got); else n_pass++;
        n_chk++; if (got[b_got] !== 8'h11) $display("FAIL basic_w0: got %h want 11", got[b_got]); else n_pass++;
        n_chk++; if (got[b_got+1] !== 8'h22) $display("FAIL basic_w1: got %h want 22", got[b_got+1]); else n_pass++;
        n_chk++; if (got[b_got+2] !== 8'h33) $display("FAIL basic_w2: got %h want 33", got[b_got+2]); else n_pass++;
        n_chk++; if (got_cyc[b_got+2] - got_cyc[b_got] !== 2)
            $display("FAIL basic_consecutive: got span %0d want 2", got_cyc[b_got+2] - got_cyc[b_got]); else n_pass++;
        n_chk++; if (word_cnt !== 16'd3) $display("FAIL basic_word_cnt: got %0d want 3", word_cnt); else n_pass++;
        n_chk++; if (n_bad_rd !== 0) $display("FAIL basic_rd_when_empty: got %0d want 0", n_bad_rd); else n_pass++;
        enable = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL basic_idle: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] first_d;
        int         seen;
        int         stable_err;
        int         order_err;
        int         gap_err;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        bus.m_ready = 1'b0;
        enable      = 1'b1;
        seen = 0; stable_err = 0; first_d = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.m_valid) begin
                if (seen == 0) begin
                    seen    = 1;
                    first_d = bus.m_data;
                end else if (bus.m_data !== first_d) begin
                    stable_err++;
                end
            end else if (seen != 0) begin
                stable_err++;
            end
        end
        n_chk++; if (n_rd - b_rd !== 2) $display("FAIL bp_reads: got %0d want 2", n_rd - b_rd); else n_pass++;
        n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en_low: got %b want 0", bus.fifo_rd_en); else n_pass++;
        n_chk++; if (stable_err !== 0) $display("FAIL bp_stable: got %0d changes want 0", stable_err); else n_pass++;
        n_chk++; if (first_d !== 8'hA0) $display("FAIL bp_head: got %h want a0", first_d); else n_pass++;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 30 && (n_got - b_got) < 8; k++) tick();
        order_err = 0; gap_err = 0;
        for (int i = 0; i < 8; i++) begin
            if (got[b_got+i] !== 8'(8'hA0 + i)) order_err++;
            if ((i > 0) && (got_cyc[b_got+i] - got_cyc[b_got+i-1] != 1)) gap_err++;
        end
        n_chk++; if (n_got - b_got !== 8) $display("FAIL bp_words: got %0d want 8", n_got - b_got); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL bp_order: got %0d errors want 0", order_err); else n_pass++;
        n_chk++; if (gap_err !== 0) $display("FAIL bp_back_to_back: got %0d gaps want 0", gap_err); else n_pass++;
        enable = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_random_ready();
        int order_err;
        do_reset();
        for (int i = 0; i < 100; i++) push(8'(i));
        enable = 1'b1;
        for (int k = 0; k < 2000 && (n_got - b_got) < 100; k++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.m_ready = 1'b0;
        order_err = 0;
        for (int i = 0; i < 100; i++) if (got[b_got+i] !== 8'(i)) order_err++;
        n_chk++; if (n_got - b_got !== 100) $display("FAIL rand_words: got %0d want 100", n_got - b_got); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL rand_order: got %0d errors want 0", order_err); else n_pass++;
        n_chk++; if (n_bad_rd !== 0) $display("FAIL rand_rd_when_empty: got %0d want 0", n_bad_rd); else n_pass++;
        n_chk++; if (n_ovf !== 0) $display("FAIL rand_occ_over_2: got %0d want 0", n_ovf); else n_pass++;
        n_chk++; if (word_cnt !== 16'd100) $display("FAIL rand_word_cnt: got %0d want 100", word_cnt); else n_pass++;
        enable = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_stop_pending();
        do_reset();
        push(8'h5A); push(8'h5B); push(8'h5C);
        bus.m_ready = 1'b0;
        enable      = 1'b1;
        tick(); tick(); tick();
        // One word is buffered and the second read is in flight
        enable = 1'b0;
        n_chk++; if (n_rd - b_rd !== 2) $display("FAIL stop_pre_reads: got %0d want 2", n_rd - b_rd); else n_pass++;
        n_chk++; if (bus.m_valid !== 1'b1) $display("FAIL stop_pre_valid: got %b want 1", bus.m_valid); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b1) $display("FAIL stop_busy_in_stop: got %b want 1", busy); else n_pass++;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 20 && busy; k++) tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL stop_busy_falls: got %b want 0", busy); else n_pass++;
        n_chk++; if (n_got - b_got !== 2) $display("FAIL stop_words: got %0d want 2", n_got - b_got); else n_pass++;
        n_chk++; if (got[b_got] !== 8'h5A) $display("FAIL stop_w0: got %h want 5a", got[b_got]); else n_pass++;
        n_chk++; if (got[b_got+1] !== 8'h5B) $display("FAIL stop_w1: got %h want 5b", got[b_got+1]); else n_pass++;
        for (int k = 0; k < 5; k++) tick();
        n_chk++; if (n_rd - b_rd !== 2) $display("FAIL stop_no_more_reads: got %0d want 2", n_rd - b_rd); else n_pass++;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        int b_got2;
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        tick(); tick(); tick(); tick();
        bus.m_ready = 1'b0;
        tick(); tick(); tick(); tick();
        n_chk++; if (word_cnt !== 16'd1) $display("FAIL rstmid_pre_cnt: got %0d want 1", word_cnt); else n_pass++;
        n_chk++; if ((n_rd - b_rd) - (n_got - b_got) !== 2)
            $display("FAIL rstmid_pre_buffered: got %0d want 2", (n_rd - b_rd) - (n_got - b_got)); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (bus.m_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_chk++; if (word_cnt !== 16'd0) $display("FAIL rstmid_word_cnt: got %0d want 0", word_cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        b_got2 = n_got;
        push(8'h77);
        bus.m_ready = 1'b1;
        for (int k = 0; k < 10 && n_got == b_got2; k++) tick();
        tick(); tick(); tick();
        n_chk++; if (n_got - b_got2 !== 1) $display("FAIL rstmid_words_after: got %0d want 1", n_got - b_got2); else n_pass++;
        n_chk++; if (got[b_got2] !== 8'h77) $display("FAIL rstmid_first_after: got %h want 77", got[b_got2]); else n_pass++;
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 18; i++) push(8'(8'h40 + i));
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        for (int k = 0; k < 60 && (n_got - b_got) < 18; k++) tick();
        n_chk++; if (word_cnt4 !== 4'd2) $display("FAIL wrap_cnt4: got %0d want 2", word_cnt4); else n_pass++;
        n_chk++; if (word_cnt !== 16'd18) $display("FAIL wrap_cnt16: got %0d want 18", word_cnt); else n_pass++;
        enable = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (busy4 !== 1'b0) $display("FAIL wrap_idle: got busy %b want 0", busy4); else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_random_ready();
        test_stop_pending();
        test_reset_mid_stream();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the synchronous FIFO: it drains the FIFO through its `rd_en`/`empty` interface and presents the words as a valid/ready stream to a downstream consumer. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so it sustains one word per clock. It also provides enable/stop control and a delivered-word counter. It sits between the FIFO read port and any consumer: a checker, a serializer or a bus master.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of FIFO read data and stream data.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  level; 1 = drain the FIFO, 0 = stop issuing reads.
- `fifo_rd_en`  out  1  read strobe to the FIFO `rd_en`.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO `rd_data`, valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_ready`  in  1  consumer accepts the word when `m_valid && m_ready`.
- `busy`  out  1  1 whenever the state is not IDLE.
- `word_cnt`  out  CNT_WIDTH  count of stream handshakes since reset; wraps modulo 2^CNT_WIDTH.

## Operation
- **State machine states:**
  - IDLE: no reads.
  - RUN: reads allowed.
  - STOP: no new reads; buffered and in-flight words are still delivered.
- **Transitions:**
  - IDLE -> RUN when `enable` = 1.
  - RUN -> STOP when `enable` = 0.
  - STOP -> IDLE when the buffer is empty, no read is in flight and `enable` = 0.
  - STOP -> RUN when `enable` = 1.
- **Read issue (combinational):** `fifo_rd_en = (state == RUN) && !fifo_empty && (occ + inflight - pop) <= 1`.
  - `occ` is the number of buffered words (0..2).
  - `inflight` is `fifo_rd_en` registered by one cycle.
  - `pop` is `m_valid && m_ready`.
- `fifo_rd_en` is never asserted while `fifo_empty` = 1. Overflow of the 2-entry buffer cannot occur; the buffer has no backpressure path to the FIFO other than withholding `fifo_rd_en`.
- **Capture:** in a cycle where `inflight` = 1, `fifo_rd_data` is written into the buffer tail at the clock edge.
- **Output:** the buffer head drives `m_data`, and `m_valid = (occ != 0)` comes from registered state.
- **Ordering:** words leave in FIFO order, with no loss and no duplication.
- **Simultaneous capture and pop:** the head advances and the tail is written in the same edge, so `occ` is unchanged.
- `word_cnt` increments by 1 on every handshake, in every state.

## Timing
- **Reset (synchronous):** state = IDLE, `occ` = 0, `inflight` = 0. Outputs:
  - `fifo_rd_en` = 0
  - `m_valid` = 0
  - `m_data` = 0
  - `busy` = 0
  - `word_cnt` = 0
- **Reset mid-operation:** buffered words and any in-flight read data are discarded. Reset has priority over all other events.
- **First-word latency:** `enable` is sampled high at edge E0, so state = RUN after E0.
  - `fifo_rd_en` = 1 in the cycle after E0, if the FIFO is not empty.
  - The FIFO's read data is captured at E2.
  - `m_valid` = 1 after E2, i.e. 2 cycles after the first `fifo_rd_en`.
- **Throughput:** 1 word/cycle while `m_ready` = 1 and the FIFO is not empty.
- **Backpressure:**
  - With `m_ready` = 0, at most 2 words are buffered; `fifo_rd_en` drops once `occ + inflight` = 2.
  - Reads resume in the same cycle `m_ready` returns to 1.
- **Stream rules:** while `m_valid && !m_ready`, `m_data` and `m_valid` are held stable. `m_valid` never depends combinationally on `m_ready`.
- **Empty FIFO in RUN:** `fifo_rd_en` = 0; the block stays in RUN and resumes when `fifo_empty` falls.
- **`enable` falls with a read in flight:** that word is still captured and delivered before IDLE.
- `busy` is registered and follows the state.

## Test plan
- **Basic drain:** FIFO preloaded with 0x11, 0x22, 0x33; `enable` = 1; `m_ready` = 1.
  - Required: exactly 3 `fifo_rd_en` pulses, and `m_data` = 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: first `m_valid` 3 cycles after `enable` rises; `word_cnt` = 3; no `fifo_rd_en` after `empty` rises.
- **Backpressure:** FIFO holds 8 words; `m_ready` = 0 for 10 cycles, then 1.
  - Required: exactly 2 reads issued, then `fifo_rd_en` = 0; `m_data` stable during the stall.
  - Required: all 8 words in order, back-to-back once `m_ready` = 1.
- **Random `m_ready`:** random `m_ready` (50%) over 100 words 0..99.
  - Required: scoreboard matches order; `fifo_rd_en` never 1 while `fifo_empty` = 1; `occ` never exceeds 2; `word_cnt` = 100.
- **Stop with data pending:** drop `enable` while a read is in flight and 1 word is buffered.
  - Required: both words delivered, state passes STOP -> IDLE, `busy` falls, and no further reads.
- **Reset mid-stream:** assert `rst` for 1 cycle with 2 words buffered.
  - Required: next cycle `m_valid` = 0, `word_cnt` = 0, `busy` = 0, and no stale word appears afterwards.
- **Counter wrap:** `CNT_WIDTH` = 4; stream 18 words.
  - Required: `word_cnt` = 2.
